// File: rtl/cpu_pkg.sv
// Shared fetch-stage types and constants for the CPU front end.
package cpu_pkg;
  localparam int INST_W = 32;
  localparam int PC_W   = 32;
  localparam logic [INST_W-1:0] NOP_INST     = 32'h0000_0000;
  localparam logic [PC_W-1:0]   RESET_PC_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {BOOT, RUN, FAULT} fetch_state_e;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [PC_W-1:0]   pc;
  } if_id_t;

  // A PC is fetchable only if word-aligned and inside the populated ROM.
  function automatic logic pc_bad(input logic [PC_W-1:0] pc, input logic [31:0] words);
    return (pc[1:0] != 2'b00) || ({2'b00, pc[PC_W-1:2]} >= words);
  endfunction
endpackage

// File: rtl/if_id_slot.sv
// One-entry IF/ID register: flush clears valid, load captures a new entry.
module if_id_slot
  import cpu_pkg::*;
(
  input  logic   clk,
  input  logic   resetn,
  input  logic   flush,
  input  logic   load,
  input  if_id_t load_data,
  output logic   valid,
  output if_id_t data
);
  logic   valid_q, valid_d;
  if_id_t data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q <= 1'b0;
      data_q  <= '{inst: NOP_INST, pc: '0};
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;
endmodule

// File: rtl/inst_fetch.sv
// Instruction-fetch front end: PC, async-ROM addressing, redirect/fault FSM
// and the IF/ID handshake slot.
module inst_fetch
  import cpu_pkg::*;
#(
  parameter int              ADDR_W    = 5,
  parameter int              ROM_WORDS = 24,
  parameter logic [PC_W-1:0] RESET_PC  = RESET_PC_DEF
) (
  input  logic              clk,
  input  logic              resetn,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [INST_W-1:0] rom_inst,
  input  logic              redirect_valid,
  input  logic [PC_W-1:0]   redirect_pc,
  input  logic              id_ready,
  output logic              id_valid,
  output logic [INST_W-1:0] id_inst,
  output logic [PC_W-1:0]   id_pc,
  output logic              fetch_fault,
  output logic [31:0]       fetch_cnt
);
  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            fault_q, fault_d;
  logic [31:0]     cnt_q, cnt_d;
  logic            flush, load, accept;
  if_id_t          slot_in, slot_out;

  assign rom_addr = pc_q[ADDR_W+1:2];
  assign accept   = !id_valid || id_ready;
  assign slot_in  = '{inst: rom_inst, pc: pc_q};

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    fault_d = fault_q;
    flush   = 1'b0;
    load    = 1'b0;
    cnt_d   = cnt_q + {31'd0, id_valid && id_ready};
    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (redirect_valid) begin
          // Redirect wins over a stalled slot: the wrong-path entry is dropped.
          pc_d  = redirect_pc;
          flush = 1'b1;
          if (pc_bad(redirect_pc, 32'(ROM_WORDS))) begin
            state_d = FAULT;
            fault_d = 1'b1;
          end
        end else if (pc_bad(pc_q, 32'(ROM_WORDS))) begin
          state_d = FAULT;
          fault_d = 1'b1;
          flush   = 1'b1;
        end else if (accept) begin
          load = 1'b1;
          pc_d = pc_q + 32'd4;
        end
      end
      FAULT: flush = 1'b1;
      default: state_d = FAULT;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      fault_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      fault_q <= fault_d;
      cnt_q   <= cnt_d;
    end
  end

  if_id_slot u_slot (
    .clk      (clk),
    .resetn   (resetn),
    .flush    (flush),
    .load     (load),
    .load_data(slot_in),
    .valid    (id_valid),
    .data     (slot_out)
  );

  assign id_inst     = slot_out.inst;
  assign id_pc       = slot_out.pc;
  assign fetch_fault = fault_q;
  assign fetch_cnt   = cnt_q;
endmodule

// File: tb/tb_inst_fetch.sv
// Randomized and directed check of inst_fetch against a cycle-level reference model.
module tb_inst_fetch;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [4:0]  rom_addr;
  logic [31:0] rom_inst;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        id_ready = 1'b0;
  logic        id_valid;
  logic [31:0] id_inst, id_pc, fetch_cnt;
  logic        fetch_fault;

  logic [31:0] rom_mem [32];
  int n_chk = 0, n_err = 0;

  // reference model state: st 0=idle after reset, 1=fetching, 2=dead
  int          m_st;
  logic [31:0] m_pc, m_inst, m_ipc, m_cnt;
  bit          m_valid, m_fault;

  always #5 clk = ~clk;
  assign rom_inst = rom_mem[rom_addr];

  inst_fetch dut (
    .clk(clk), .resetn(resetn), .rom_addr(rom_addr), .rom_inst(rom_inst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_ready(id_ready), .id_valid(id_valid), .id_inst(id_inst), .id_pc(id_pc),
    .fetch_fault(fetch_fault), .fetch_cnt(fetch_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit bad(input logic [31:0] p);
    return (p % 4 != 0) || ((p / 4) >= 24);
  endfunction

  task automatic do_reset();
    resetn = 1'b0;
    #1;
    m_st = 0; m_pc = 0; m_valid = 0; m_inst = 0; m_ipc = 0; m_cnt = 0; m_fault = 0;
    chk("rst_valid", {31'd0, id_valid}, 0);
    chk("rst_inst", id_inst, 0);
    chk("rst_pc", id_pc, 0);
    chk("rst_fault", {31'd0, fetch_fault}, 0);
    chk("rst_cnt", fetch_cnt, 0);
    chk("rst_addr", {27'd0, rom_addr}, 0);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic cyc(input bit rv, input logic [31:0] rpc, input bit rdy);
    int          n_st;
    logic [31:0] n_pc, n_inst, n_ipc, n_cnt;
    bit          n_valid, n_fault;
    redirect_valid = rv; redirect_pc = rpc; id_ready = rdy;
    #1;
    chk("rom_addr", {27'd0, rom_addr}, {27'd0, m_pc[6:2]});
    n_st = m_st; n_pc = m_pc; n_inst = m_inst; n_ipc = m_ipc;
    n_valid = m_valid; n_fault = m_fault;
    n_cnt = (m_valid && rdy) ? m_cnt + 1 : m_cnt;
    if (m_st == 0) n_st = 1;
    else if (m_st == 2) n_valid = 0;
    else if (rv) begin
      n_pc = rpc; n_valid = 0;
      if (bad(rpc)) begin n_st = 2; n_fault = 1; end
    end else if (bad(m_pc)) begin
      n_st = 2; n_fault = 1; n_valid = 0;
    end else if (!m_valid || rdy) begin
      n_inst = rom_mem[m_pc / 4]; n_ipc = m_pc; n_valid = 1; n_pc = m_pc + 4;
    end
    @(posedge clk);
    #1;
    m_st = n_st; m_pc = n_pc; m_inst = n_inst; m_ipc = n_ipc;
    m_valid = n_valid; m_fault = n_fault; m_cnt = n_cnt;
    chk("id_valid", {31'd0, id_valid}, {31'd0, m_valid});
    if (m_valid) begin
      chk("id_inst", id_inst, m_inst);
      chk("id_pc", id_pc, m_ipc);
    end
    chk("fault", {31'd0, fetch_fault}, {31'd0, m_fault});
    chk("cnt", fetch_cnt, m_cnt);
  endtask

  initial begin
    logic [31:0] tgt;
    for (int i = 0; i < 32; i++) rom_mem[i] = $urandom;
    rom_mem[0] = 32'h24010001; rom_mem[1] = 32'h00011100; rom_mem[2] = 32'h00411821;
    rom_mem[3] = 32'h00022082; rom_mem[4] = 32'h00642823; rom_mem[13] = 32'h8C2A0013;

    // free run from reset
    do_reset();
    cyc(0, 0, 1);
    chk("boot_idle", {31'd0, id_valid}, 0);
    cyc(0, 0, 1);
    chk("first_pc", id_pc, 32'h0); chk("first_inst", id_inst, 32'h24010001);
    cyc(0, 0, 1);
    chk("second_inst", id_inst, 32'h00011100);
    cyc(0, 0, 1);
    chk("third_pc", id_pc, 32'h08); chk("third_inst", id_inst, 32'h00411821);
    cyc(0, 0, 1);
    chk("cnt3", fetch_cnt, 3);
    // stall on 0x0C
    for (int i = 0; i < 3; i++) cyc(0, 0, 0);
    chk("stall_inst", id_inst, 32'h00022082);
    chk("stall_addr", {27'd0, rom_addr}, 4);
    chk("stall_cnt", fetch_cnt, 3);
    cyc(0, 0, 1);
    chk("release_pc", id_pc, 32'h10); chk("release_inst", id_inst, 32'h00642823);
    for (int i = 0; i < 7; i++) cyc(0, 0, 1);
    chk("at_2c", id_pc, 32'h2C);
    cyc(1, 32'h34, 1);
    chk("redir_flush", {31'd0, id_valid}, 0);
    cyc(0, 0, 1);
    chk("redir_pc", id_pc, 32'h34); chk("redir_inst", id_inst, 32'h8C2A0013);
    for (int i = 0; i < 10; i++) cyc(0, 0, 1);
    chk("at_5c", id_pc, 32'h5C);
    cyc(1, 32'h0, 1);
    cyc(0, 0, 1);
    chk("wrap_pc", id_pc, 32'h0); chk("wrap_inst", id_inst, 32'h24010001);
    chk("wrap_nofault", {31'd0, fetch_fault}, 0);
    cyc(1, 32'h62, 1);
    chk("bad_redir_fault", {31'd0, fetch_fault}, 1);
    for (int i = 0; i < 4; i++) cyc($urandom_range(0, 1), 32'h10, $urandom_range(0, 1));
    chk("frozen_addr", {27'd0, rom_addr}, 24);

    // sequential run off the end of the ROM
    do_reset();
    for (int i = 0; i < 30; i++) cyc(0, 0, 1);
    chk("seq_fault", {31'd0, fetch_fault}, 1);
    chk("seq_cnt", fetch_cnt, 24);

    // async reset during a stall
    do_reset();
    for (int i = 0; i < 4; i++) cyc(0, 0, 1);
    cyc(0, 0, 0);
    chk("pre_rst_valid", {31'd0, id_valid}, 1);
    do_reset();
    cyc(0, 0, 1);
    cyc(0, 0, 1);
    chk("post_rst_pc", id_pc, 32'h0);
    chk("post_rst_valid", {31'd0, id_valid}, 1);

    // random episodes
    for (int e = 0; e < 4; e++) begin
      do_reset();
      for (int i = 0; i < 300; i++) begin
        tgt = ($urandom_range(0, 19) == 0) ? $urandom : 32'($urandom_range(0, 23)) * 4;
        cyc($urandom_range(0, 9) == 0, tgt, $urandom_range(0, 3) != 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
